fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_mac_sequencer_if.sv | 42 ++++
 rtl/fir_tap_counter.sv | 42 ++++
 rtl/fir_mac_sequencer.sv | 158 +++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and helpers for the FIR MAC sequencer.
// Instances override the widths through parameters; these are only the defaults.
package fir_pkg;

    localparam int TAPS_DEF    = 10;
    localparam int COEFF_W_DEF = 16;
    localparam int ADDR_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UPDATE = 3'd1,
        ST_READ   = 3'd2,
        ST_LAST   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // True when a CPU address maps onto a real coefficient slot.
    function automatic logic tap_in_range(input int addr, input int taps);
        return (addr < taps);
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Control bus of the FIR MAC sequencer: sample strobe, CPU coefficient port,
// coefficient SRAM port and MAC datapath controls; no flow control on any of it.
interface fir_mac_sequencer_if #(
    parameter int ADDR_W  = fir_pkg::ADDR_W_DEF,
    parameter int COEFF_W = fir_pkg::COEFF_W_DEF
);

    logic               iEnSample_600kHz;
    logic               iCoeffUpdateFlag;
    logic               iCsnRam;
    logic               iWrnRam;
    logic [ADDR_W-1:0]  iAddrRam;
    logic [COEFF_W-1:0] iWrDtRam;

    logic               oMemCsn;
    logic               oMemWrn;
    logic [ADDR_W-1:0]  oMemAddr;
    logic [COEFF_W-1:0] oMemWrDt;
    logic [ADDR_W-1:0]  oDelayAddr;
    logic               oMacEn;
    logic               oMacClr;
    logic               oAccDone;
    logic               oBusy;
    logic               oSampleSkip;
    logic               oOverrun;
    logic               oAddrErr;

    // Environment side: drives strobe and CPU port, observes SRAM/MAC controls.
    modport master (
        output iEnSample_600kHz, iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
        input  oMemCsn, oMemWrn, oMemAddr, oMemWrDt, oDelayAddr,
        input  oMacEn, oMacClr, oAccDone, oBusy, oSampleSkip, oOverrun, oAddrErr
    );

    // Sequencer side.
    modport slave (
        input  iEnSample_600kHz, iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
        output oMemCsn, oMemWrn, oMemAddr, oMemWrDt, oDelayAddr,
        output oMacEn, oMacClr, oAccDone, oBusy, oSampleSkip, oOverrun, oAddrErr
    );

endinterface

// File: rtl/fir_tap_counter.sv
// Tap index counter: clear wins over enable, counting stops at TAPS-1 and
// tc_o flags that terminal index combinationally from the registered count.
module fir_tap_counter
    import fir_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences TAPS coefficient reads and MAC enables per sample strobe (strobe->oAccDone = TAPS+2 clocks)
// and hands the coefficient SRAM to the CPU between samples; no backpressure, surplus strobes are flagged.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS    = TAPS_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               iClk_12MHz,
    input  logic               iRst,
    fir_mac_sequencer_if.slave bus
);

    state_e             state_q;
    logic               mem_csn_q;
    logic               mem_wrn_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [COEFF_W-1:0] mem_wrdt_q;
    logic [ADDR_W-1:0]  delay_addr_q;
    logic               mac_en_q;
    logic               mac_clr_q;
    logic               acc_done_q;
    logic               busy_q;
    logic               skip_q;
    logic               overrun_q;
    logic               addr_err_q;

    logic [ADDR_W-1:0]  tap_cnt;
    logic               tap_tc;
    logic [ADDR_W-1:0]  rd_addr_d;
    logic               strobe;
    logic               cpu_sel;
    logic               cpu_addr_ok;

    assign strobe      = bus.iEnSample_600kHz;
    assign cpu_sel     = !bus.iCsnRam;
    assign cpu_addr_ok = tap_in_range(int'(bus.iAddrRam), TAPS);
    assign rd_addr_d   = tap_cnt + 1'b1;

    // The counter holds zero outside READ, so every sequence starts at tap 0.
    fir_tap_counter #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) u_tap_counter (
        .clk_i  (iClk_12MHz),
        .rst_i  (iRst),
        .clr_i  (state_q != ST_READ),
        .en_i   (state_q == ST_READ),
        .cnt_o  (tap_cnt),
        .tc_o   (tap_tc)
    );

    always_ff @(posedge iClk_12MHz) begin
        if (iRst) begin
            state_q      <= ST_IDLE;
            mem_csn_q    <= 1'b1;
            mem_wrn_q    <= 1'b1;
            mem_addr_q   <= '0;
            mem_wrdt_q   <= '0;
            delay_addr_q <= '0;
            mac_en_q     <= 1'b0;
            mac_clr_q    <= 1'b0;
            acc_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            skip_q       <= 1'b0;
            overrun_q    <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            // SRAM read data lands one clock after each READ cycle; the MAC follows it.
            mac_en_q   <= (state_q == ST_READ);
            mac_clr_q  <= (state_q == ST_READ) && (tap_cnt == '0);
            acc_done_q <= 1'b0;
            skip_q     <= 1'b0;
            overrun_q  <= 1'b0;
            addr_err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    mem_csn_q <= 1'b1;
                    mem_wrn_q <= 1'b1;
                    if (bus.iCoeffUpdateFlag) begin
                        state_q <= ST_UPDATE;
                        skip_q  <= strobe;
                    end else if (strobe) begin
                        state_q      <= ST_READ;
                        mem_csn_q    <= 1'b0;
                        mem_addr_q   <= '0;
                        delay_addr_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end

                ST_UPDATE: begin
                    skip_q <= strobe;
                    if (!bus.iCoeffUpdateFlag) begin
                        state_q   <= ST_IDLE;
                        mem_csn_q <= 1'b1;
                        mem_wrn_q <= 1'b1;
                    end else begin
                        // Out-of-range CPU addresses never select the SRAM.
                        mem_csn_q  <= !(cpu_sel && cpu_addr_ok);
                        mem_wrn_q  <= bus.iWrnRam;
                        mem_addr_q <= bus.iAddrRam;
                        mem_wrdt_q <= bus.iWrDtRam;
                        addr_err_q <= cpu_sel && !cpu_addr_ok;
                    end
                end

                ST_READ: begin
                    overrun_q <= strobe;
                    if (tap_tc) begin
                        state_q      <= ST_LAST;
                        mem_csn_q    <= 1'b1;
                        mem_addr_q   <= '0;
                        delay_addr_q <= '0;
                    end else begin
                        mem_addr_q   <= rd_addr_d;
                        delay_addr_q <= rd_addr_d;
                    end
                end

                ST_LAST: begin
                    overrun_q  <= strobe;
                    acc_done_q <= 1'b1;
                    state_q    <= ST_DONE;
                end

                ST_DONE: begin
                    overrun_q <= strobe;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    mem_csn_q <= 1'b1;
                    mem_wrn_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oMemCsn     = mem_csn_q;
    assign bus.oMemWrn     = mem_wrn_q;
    assign bus.oMemAddr    = mem_addr_q;
    assign bus.oMemWrDt    = mem_wrdt_q;
    assign bus.oDelayAddr  = delay_addr_q;
    assign bus.oMacEn      = mac_en_q;
    assign bus.oMacClr     = mac_clr_q;
    assign bus.oAccDone    = acc_done_q;
    assign bus.oBusy       = busy_q;
    assign bus.oSampleSkip = skip_q;
    assign bus.oOverrun    = overrun_q;
    assign bus.oAddrErr    = addr_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: randomized scenarios checked against a cycle-timeline model.
module tb_fir_mac_sequencer;

    localparam int T  = 10;
    localparam int AW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic          csn;
        logic          wrn;
        logic [AW-1:0] addr;
        logic [CW-1:0] wrdt;
        logic [AW-1:0] daddr;
        logic          mac_en;
        logic          mac_clr;
        logic          acc_done;
        logic          busy;
        logic          skip;
        logic          overrun;
        logic          addr_err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fir_mac_sequencer_if #(.ADDR_W(AW), .COEFF_W(CW)) bus ();

    fir_mac_sequencer #(.TAPS(T), .COEFF_W(CW), .ADDR_W(AW)) dut (
        .iClk_12MHz (clk),
        .iRst       (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iEnSample_600kHz = 1'b0;
        bus.iCoeffUpdateFlag = 1'b0;
        bus.iCsnRam          = 1'b1;
        bus.iWrnRam          = 1'b1;
        bus.iAddrRam         = '0;
        bus.iWrDtRam         = '0;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.csn      = bus.oMemCsn;
        o.wrn      = bus.oMemWrn;
        o.addr     = bus.oMemAddr;
        o.wrdt     = bus.oMemWrDt;
        o.daddr    = bus.oDelayAddr;
        o.mac_en   = bus.oMacEn;
        o.mac_clr  = bus.oMacClr;
        o.acc_done = bus.oAccDone;
        o.busy     = bus.oBusy;
        o.skip     = bus.oSampleSkip;
        o.overrun  = bus.oOverrun;
        o.addr_err = bus.oAddrErr;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t e;
        e     = '0;
        e.csn = 1'b1;
        e.wrn = 1'b1;
        return e;
    endfunction

    // Expected outputs c cycles after the strobe edge of an undisturbed sequence.
    function automatic void seq_exp(input int c, output obs_t e, output obs_t m);
        logic rd;
        rd     = (c >= 1) && (c <= T);
        e      = '0;
        m      = '1;
        m.wrdt = '0;
        e.csn  = !rd;
        e.wrn  = 1'b1;
        if (rd) begin
            e.addr  = AW'(c - 1);
            e.daddr = AW'(c - 1);
        end else begin
            m.addr  = '0;
            m.daddr = '0;
            m.wrn   = 1'b0;
        end
        e.mac_en   = (c >= 2) && (c <= T + 1);
        e.mac_clr  = (c == 2);
        e.acc_done = (c == T + 2);
        e.busy     = (c >= 1) && (c <= T + 2);
    endfunction

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        idle_inputs();
        bus.iEnSample_600kHz = 1'b1;
        tick();
        tick();
        o = sample();
        checks++;
        if (o !== reset_obs()) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", o, reset_obs());
        end
        rst = 1'b0;
        bus.iEnSample_600kHz = 1'b0;
        tick();
        o = sample();
        checks++;
        if (o !== reset_obs()) begin
            failures++;
            $display("FAIL reset_release_idle got=%h exp=%h", o, reset_obs());
        end
    endtask

    // Plain sequences with random idle gaps and random CPU noise while the flag is low.
    task automatic test_single_sequence();
        obs_t o, e, m;
        for (int r = 0; r < 4; r++) begin
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) tick();
            bus.iEnSample_600kHz = 1'b1;
            tick();
            bus.iEnSample_600kHz = 1'b0;
            for (int c = 1; c <= T + 3; c++) begin
                seq_exp(c, e, m);
                o = sample();
                checks++;
                if ((o & m) !== (e & m)) begin
                    failures++;
                    $display("FAIL seq r=%0d c=%0d got=%h exp=%h mask=%h", r, c, o, e, m);
                end
                bus.iCsnRam  = 1'($urandom_range(0, 1));
                bus.iWrnRam  = 1'($urandom_range(0, 1));
                bus.iAddrRam = AW'($urandom_range(0, 15));
                bus.iWrDtRam = CW'($urandom);
                tick();
            end
            idle_inputs();
        end
    endtask

    task automatic test_update();
        obs_t o, e, m;
        int writes_seen;
        int writes_exp;
        logic          cs_n, wr_n;
        logic [AW-1:0] a;
        logic [CW-1:0] d;
        writes_seen = 0;
        writes_exp  = 0;
        bus.iCoeffUpdateFlag = 1'b1;
        tick();
        o = sample();
        checks++;
        if (o.csn !== 1'b1 || o.busy !== 1'b0 || o.addr_err !== 1'b0) begin
            failures++;
            $display("FAIL update_entry csn=%b busy=%b addr_err=%b exp 1 0 0", o.csn, o.busy, o.addr_err);
        end
        for (int i = 0; i < 18; i++) begin
            if (i < 10) begin
                cs_n = 1'b0; wr_n = 1'b0; a = AW'(i); d = CW'(i + 1);
            end else if (i == 10) begin
                cs_n = 1'b0; wr_n = 1'b0; a = AW'(12); d = CW'($urandom);
            end else begin
                cs_n = 1'($urandom_range(0, 1));
                wr_n = 1'($urandom_range(0, 1));
                a    = AW'($urandom_range(0, 15));
                d    = CW'($urandom);
            end
            bus.iCsnRam  = cs_n;
            bus.iWrnRam  = wr_n;
            bus.iAddrRam = a;
            bus.iWrDtRam = d;
            tick();
            o = sample();
            e = '0;
            m = '0;
            m.csn = 1'b1; m.addr_err = 1'b1; m.busy = 1'b1; m.mac_en = 1'b1;
            m.mac_clr = 1'b1; m.acc_done = 1'b1; m.skip = 1'b1; m.overrun = 1'b1;
            e.csn      = !(cs_n == 1'b0 && int'(a) < T);
            e.addr_err = (cs_n == 1'b0 && int'(a) >= T);
            if (!e.csn) begin
                m.wrn = 1'b1; m.addr = '1; m.wrdt = '1;
                e.wrn = wr_n; e.addr = a; e.wrdt = d;
                if (!wr_n) writes_exp++;
            end
            if (o.csn === 1'b0 && o.wrn === 1'b0) writes_seen++;
            checks++;
            if ((o & m) !== (e & m)) begin
                failures++;
                $display("FAIL cpu_access i=%0d got=%h exp=%h mask=%h", i, o, e, m);
            end
        end
        idle_inputs();
        tick();
        o = sample();
        checks++;
        if (o.csn !== 1'b1 || o.busy !== 1'b0 || o.addr_err !== 1'b0) begin
            failures++;
            $display("FAIL update_exit csn=%b busy=%b addr_err=%b exp 1 0 0", o.csn, o.busy, o.addr_err);
        end
        bus.iCsnRam  = 1'b0;
        bus.iWrnRam  = 1'b0;
        bus.iAddrRam = AW'(2);
        bus.iWrDtRam = CW'($urandom);
        tick();
        o = sample();
        checks++;
        if (o.csn !== 1'b1 || o.addr_err !== 1'b0) begin
            failures++;
            $display("FAIL cpu_outside_update csn=%b addr_err=%b exp 1 0", o.csn, o.addr_err);
        end
        idle_inputs();
        tick();
        checks++;
        if (writes_seen !== writes_exp || writes_exp < 10) begin
            failures++;
            $display("FAIL write_count got=%0d exp=%0d", writes_seen, writes_exp);
        end
    endtask

    task automatic test_skip();
        obs_t o;
        bus.iCoeffUpdateFlag = 1'b1;
        bus.iEnSample_600kHz = 1'b1;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        o = sample();
        checks++;
        if (o.skip !== 1'b1 || o.busy !== 1'b0 || o.csn !== 1'b1 || o.mac_en !== 1'b0) begin
            failures++;
            $display("FAIL skip_idle skip=%b busy=%b csn=%b mac_en=%b exp 1 0 1 0", o.skip, o.busy, o.csn, o.mac_en);
        end
        tick();
        o = sample();
        checks++;
        if (o.skip !== 1'b0 || o.csn !== 1'b1) begin
            failures++;
            $display("FAIL skip_one_clock skip=%b csn=%b exp 0 1", o.skip, o.csn);
        end
        bus.iEnSample_600kHz = 1'b1;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        o = sample();
        checks++;
        if (o.skip !== 1'b1 || o.busy !== 1'b0 || o.overrun !== 1'b0) begin
            failures++;
            $display("FAIL skip_update skip=%b busy=%b overrun=%b exp 1 0 0", o.skip, o.busy, o.overrun);
        end
        bus.iCoeffUpdateFlag = 1'b0;
        tick();
        tick();
        o = sample();
        checks++;
        if (o.skip !== 1'b0 || o.busy !== 1'b0) begin
            failures++;
            $display("FAIL skip_cleared skip=%b busy=%b exp 0 0", o.skip, o.busy);
        end
    endtask

    task automatic test_overrun();
        obs_t o, e, m;
        int k;
        for (int r = 0; r < 4; r++) begin
            k = (r == 0) ? 5 : int'($urandom_range(1, T + 2));
            bus.iEnSample_600kHz = 1'b1;
            tick();
            bus.iEnSample_600kHz = 1'b0;
            for (int c = 1; c <= T + 5; c++) begin
                seq_exp(c, e, m);
                e.overrun = (c == k + 1);
                o = sample();
                checks++;
                if ((o & m) !== (e & m)) begin
                    failures++;
                    $display("FAIL overrun k=%0d c=%0d got=%h exp=%h mask=%h", k, c, o, e, m);
                end
                bus.iEnSample_600kHz = (c == k);
                tick();
            end
            bus.iEnSample_600kHz = 1'b0;
        end
    endtask

    task automatic test_flag_mid();
        obs_t o, e, m;
        int fc;
        logic [CW-1:0] d;
        fc = int'($urandom_range(2, 8));
        d  = CW'($urandom);
        bus.iEnSample_600kHz = 1'b1;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        for (int c = 1; c <= T + 2; c++) begin
            seq_exp(c, e, m);
            o = sample();
            checks++;
            if ((o & m) !== (e & m)) begin
                failures++;
                $display("FAIL flag_mid fc=%0d c=%0d got=%h exp=%h mask=%h", fc, c, o, e, m);
            end
            if (c >= fc) bus.iCoeffUpdateFlag = 1'b1;
            bus.iCsnRam = (c == 5) ? 1'b0 : 1'b1;
            bus.iWrnRam = 1'b0;
            bus.iAddrRam = AW'(1);
            tick();
        end
        bus.iCsnRam  = 1'b0;
        bus.iWrnRam  = 1'b0;
        bus.iAddrRam = AW'(3);
        bus.iWrDtRam = d;
        tick();
        o = sample();
        checks++;
        if (o.csn !== 1'b1 || o.busy !== 1'b0 || o.skip !== 1'b0) begin
            failures++;
            $display("FAIL flag_mid_entry csn=%b busy=%b skip=%b exp 1 0 0", o.csn, o.busy, o.skip);
        end
        tick();
        o = sample();
        checks++;
        if (o.csn !== 1'b0 || o.wrn !== 1'b0 || o.addr !== AW'(3) || o.wrdt !== d) begin
            failures++;
            $display("FAIL flag_mid_write csn=%b wrn=%b addr=%h wrdt=%h exp 0 0 3 %h", o.csn, o.wrn, o.addr, o.wrdt, d);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        obs_t o, e, m;
        int bad;
        bad = 0;
        bus.iEnSample_600kHz = 1'b1;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            seq_exp(c, e, m);
            o = sample();
            checks++;
            if ((o & m) !== (e & m)) begin
                failures++;
                $display("FAIL pre_reset c=%0d got=%h exp=%h mask=%h", c, o, e, m);
            end
            if (c == 6) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        o = sample();
        checks++;
        if (o !== reset_obs()) begin
            failures++;
            $display("FAIL mid_reset_values got=%h exp=%h", o, reset_obs());
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            o = sample();
            if (o.acc_done !== 1'b0 || o.busy !== 1'b0 || o.csn !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_done bad_cycles=%0d exp 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int acc_cnt, ov_cnt, pos_err;
        acc_cnt = 0;
        ov_cnt  = 0;
        pos_err = 0;
        for (int i = 0; i < 128; i++) begin
            for (int j = 0; j < 20; j++) begin
                bus.iEnSample_600kHz = (j == 0);
                tick();
                o = sample();
                if (o.acc_done === 1'b1) acc_cnt++;
                if (o.overrun === 1'b1) ov_cnt++;
                if (o.acc_done !== (j == T + 1)) pos_err++;
            end
        end
        bus.iEnSample_600kHz = 1'b0;
        checks++;
        if (acc_cnt !== 128) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=128", acc_cnt);
        end
        checks++;
        if (ov_cnt !== 0) begin
            failures++;
            $display("FAIL b2b_overrun_count got=%0d exp=0", ov_cnt);
        end
        checks++;
        if (pos_err !== 0) begin
            failures++;
            $display("FAIL b2b_done_position bad_cycles=%0d exp=0", pos_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_sequence();
        test_update();
        test_skip();
        test_overrun();
        test_flag_mid();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
